prog_freq_div: RTL
==================

# prog_freq_div

Runtime-programmable integer clock divider for the simple-PLL feedback and test paths. Divides the input clock by any ratio from 2 to 2^W-1, including odd ratios with an exact N-cycle period. New ratios are loaded through a valid/ready handshake and take effect only at a period boundary, so the output never glitches. Start and stop are graceful and aligned to period boundaries.

## Interface
- W, 16, ratio width in bits
- DEFAULT_DIV, 10, ratio in effect after reset; must satisfy 2 ≤ DEFAULT_DIV ≤ 2^W-1
- clk  input  1  input clock to divide
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  run request, sampled on posedge clk
- div_val  input  W  requested ratio N
- div_valid  input  1  div_val is valid
- div_ready  output  1  block can accept a ratio
- out  output  1  divided clock
- tick  output  1  one-cycle pulse marking the first cycle of each output period
- cur_div  output  W  ratio currently in effect
- busy  output  1  divider running (state is not IDLE)
- err  output  1  the last accepted ratio was illegal (below 2)

## Operation
- States:
  - IDLE: cnt=0, out=0.
  - RUN: counting.
  - STOP: en dropped; the current period is finishing.
- Count rule: cnt runs 0..N-1 and wraps. Let H = ceil(N/2). out=1 while cnt<H and out=0 otherwise. Even N gives 50% duty. Odd N gives H high and N-H low.
- IDLE → RUN when en=1 is sampled. On that edge: cnt←0, out←1, tick←1.
- RUN → STOP when en=0 is sampled. STOP → RUN when en=1 is sampled before the boundary; no gap is inserted.
- STOP → IDLE on the wrap edge (cnt==N-1). out is already 0 at that point. No tick is issued.
- Ratio handshake: a transfer happens when div_valid && div_ready at a posedge.
  - In IDLE: cur_div←div_val on the same edge. div_ready stays 1.
  - In RUN or STOP: div_val is latched into a pending register and div_ready←0. Pending is applied to cur_div on the next wrap edge, so the new period uses the new N. div_ready←1 on that same edge.
  - Only one pending entry exists. While it is held, further div_valid is ignored (not accepted).
- Illegal ratio (div_val<2): the transfer still completes. The value is discarded, cur_div is unchanged, and err←1. err←0 on the next legal transfer.
- Simultaneous events: an accept and the wrap edge on the same cycle is impossible because div_ready is 0 while a value is pending. When a new transfer lands on a wrap edge with nothing pending, it becomes pending for the following boundary.

## Timing
- Reset values, applied asynchronously and immediately:
  - out=0, tick=0, busy=0, err=0
  - div_ready=1
  - cur_div=DEFAULT_DIV
  - pending empty, state IDLE
- Reset asserted mid-period aborts immediately; no boundary completion.
- All outputs are registered on posedge clk (except the ODD_DUTY half-cycle path described below).
- Start latency: out rises after the first edge that samples en=1.
- Period timing, with E0 as the starting edge:
  - Rising edges of out occur at E0 + kN.
  - Falling edges occur at E0 + kN + H.
  - tick is high for exactly the one cycle following each rising edge.
- Ratio change: a pending value becomes visible on cur_div at the wrap edge. The period starting at that edge has length N_new.
- Width rule: cnt is W bits and compares against cur_div-1. There is no overflow for N up to 2^W-1.

## Configuration
- PROG_FREQ_DIV_ODD_DUTY_EN defined:
  - For odd N, a negedge-clk flop delays the falling edge of out by half a cycle. Fall is computed at H-1 and delayed on negedge, giving a high time of exactly N/2 input periods (50% duty).
  - Even N is unaffected.
  - tick and all handshake timing are unchanged.
- Macro undefined: single-edge logic only. Odd N gives H high cycles and N-H low cycles.

## Test plan
- Reset then en=1 with DEFAULT_DIV=10 → out period 10 cycles, high 5 / low 5; tick every 10 cycles coincident with out rising; busy=1.
- Load div_val=7 while running → div_ready=0 until the next wrap; then cur_div=7 and periods of 7 cycles, 4 high / 3 low (macro off) or 3.5 / 3.5 (macro on). The old period completes with its full 10 cycles.
- Load div_val=1 in IDLE → err=1, cur_div unchanged; a subsequent load of 4 → err=0, cur_div=4.
- With N=6, drop en at cnt=2 → out finishes the period (falls at cnt=3, period ends at 6), then IDLE with busy=0 and no extra tick. Re-raising en at cnt=4 instead → continuous periods with no gap.
- Second div_valid while a value is pending → not accepted; the first value is applied at the boundary, and div_ready returns to 1 on that edge.
- Assert rst_n=0 mid-high-phase → out=0, cur_div=DEFAULT_DIV, and pending cleared immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prog_freq_div.sv
// Runtime-programmable integer clock divider (N = 2..2^W-1). Ratio changes and stop land on period boundaries.
// Optional PROG_FREQ_DIV_ODD_DUTY_EN: half-cycle fall delay giving 50% duty for odd N.
module prog_freq_div #(
  parameter int W           = 16,
  parameter int DEFAULT_DIV = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] div_val,
  input  logic         div_valid,
  output logic         div_ready,
  output logic         out,
  output logic         tick,
  output logic [W-1:0] cur_div,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         out_q, out_d;
  logic         tick_q, tick_d;
  logic [W-1:0] cur_div_q, cur_div_d;
  logic         pend_vld_q, pend_vld_d;
  logic [W-1:0] pend_val_q, pend_val_d;
  logic         err_q, err_d;

  logic [W-1:0] cnt_inc;
  logic [W-1:0] hi_lim;
  logic         wrap;
  logic         accept;
  logic         legal;

  assign cnt_inc = cnt_q + W'(1);
  assign wrap    = (cnt_q == (cur_div_q - W'(1)));
  assign accept  = div_valid && !pend_vld_q;
  assign legal   = (div_val >= W'(2));

`ifdef PROG_FREQ_DIV_ODD_DUTY_EN
  // Fall one cycle early for odd N; the negedge stage below adds back half a cycle.
  assign hi_lim = cur_div_q >> 1;
`else
  assign hi_lim = (cur_div_q >> 1) + {{(W-1){1'b0}}, cur_div_q[0]};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    tick_d     = 1'b0;
    cur_div_d  = cur_div_q;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        out_d = 1'b0;
        if (en) begin
          state_d = RUN;
          out_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      RUN, STOP: begin
        if (wrap) begin
          cnt_d = '0;
          if (pend_vld_q) begin
            cur_div_d  = pend_val_q;
            pend_vld_d = 1'b0;
          end
          if (en) begin
            state_d = RUN;
            out_d   = 1'b1;
            tick_d  = 1'b1;
          end else begin
            state_d = IDLE;
            out_d   = 1'b0;
          end
        end else begin
          cnt_d   = cnt_inc;
          out_d   = (cnt_inc < hi_lim);
          state_d = en ? RUN : STOP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase

    // Illegal ratios complete the handshake but only raise err.
    if (accept) begin
      if (!legal) begin
        err_d = 1'b1;
      end else begin
        err_d = 1'b0;
        if (state_q == IDLE) begin
          cur_div_d = div_val;
        end else begin
          pend_vld_d = 1'b1;
          pend_val_d = div_val;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_q      <= 1'b0;
      tick_q     <= 1'b0;
      cur_div_q  <= W'(DEFAULT_DIV);
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      tick_q     <= tick_d;
      cur_div_q  <= cur_div_d;
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
      err_q      <= err_d;
    end
  end

`ifdef PROG_FREQ_DIV_ODD_DUTY_EN
  logic out_neg_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_neg_q <= 1'b0;
    end else begin
      out_neg_q <= out_q;
    end
  end

  assign out = out_q | (out_neg_q & cur_div_q[0]);
`else
  assign out = out_q;
`endif

  assign tick      = tick_q;
  assign cur_div   = cur_div_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign div_ready = !pend_vld_q;

endmodule
